// File: rtl/div_pkg.sv
// ============================================================
// div_pkg : shared sizes and FSM state encoding for div_top
// Rev 1.0
// ============================================================
`default_nettype none

package div_pkg;
    localparam int W  = 10;
    localparam int F  = 6;
    localparam int N  = W + F;
    localparam int CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

`default_nettype wire

// File: rtl/div_datapath.sv
// ============================================================
// div_datapath : restoring-division shift register, remainder,
// divisor and iteration counter. Rev 1.0
// ============================================================
`default_nettype none

module div_datapath
    import div_pkg::*;
#(
    parameter int W = div_pkg::W,
    parameter int F = div_pkg::F
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           clr_cnt,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           b_zero,
    output logic           cnt_done,
    output logic [W+F-1:0] quot
);
    localparam int NB   = W + F;
    localparam int CNTW = $clog2(NB) + 1;

    logic [NB-1:0]   sr_q,  sr_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    div_q, div_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [W+1:0]    trial;
    logic            ge;

    always_comb begin
        // Shift the next dividend bit into the remainder, then try the subtract
        trial = {rem_q, sr_q[NB-1]};
        ge    = (trial >= (W+2)'(div_q));
        sr_d  = sr_q;
        rem_d = rem_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = {a, {F{1'b0}}};
            rem_d = '0;
            div_d = b;
            cnt_d = '0;
        end else begin
            if (clr_cnt)
                cnt_d = '0;
            if (step) begin
                rem_d = ge ? (W+1)'(trial - (W+2)'(div_q)) : (W+1)'(trial);
                sr_d  = {sr_q[NB-2:0], ge};
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign b_zero   = (div_q == '0);
    assign cnt_done = (cnt_q == CNTW'(NB - 1));
    assign quot     = sr_q;
endmodule

`default_nettype wire

// File: rtl/div_top.sv
// ============================================================
// div_top : sequential unsigned Q4.6 divider, FSM controller
// and result registers. Rev 1.0
// ============================================================
`default_nettype none

module div_top
    import div_pkg::*;
#(
    parameter int W = div_pkg::W,
    parameter int F = div_pkg::F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         valid,
    output logic         ov,
    output logic         dvz
);
    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           ov_q, ov_d;
    logic           dvz_q, dvz_d;
    logic           load, clr_cnt, step;
    logic           b_zero, cnt_done;
    logic [W+F-1:0] quot;
    logic           quot_ov;

    div_datapath #(.W(W), .F(F)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .clr_cnt  (clr_cnt),
        .step     (step),
        .a        (A),
        .b        (B),
        .b_zero   (b_zero),
        .cnt_done (cnt_done),
        .quot     (quot)
    );

    assign quot_ov = |quot[W+F-1:W];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        ov_d    = ov_q;
        dvz_d   = dvz_q;
        load    = 1'b0;
        clr_cnt = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    ov_d    = 1'b0;
                    dvz_d   = 1'b0;
                end
            end
            LOAD: begin
                clr_cnt = 1'b1;
                state_d = b_zero ? DONE : RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt_done)
                    state_d = DONE;
            end
            DONE: begin
                // Divisor register still holds B, so b_zero marks the skipped run
                dvz_d   = b_zero;
                ov_d    = !b_zero && quot_ov;
                q_d     = (b_zero || quot_ov) ? '0 : quot[W-1:0];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
            dvz_q   <= dvz_d;
        end
    end

    assign Q     = q_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign ov    = ov_q;
    assign dvz   = dvz_q;
endmodule

`default_nettype wire

// File: tb/tb_div_top.sv
// ============================================================
// tb_div_top : directed vector bench for div_top
// Rev 1.0
// ============================================================
`default_nettype none

module tb_div_top;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] A = '0;
    logic [9:0] B = '0;
    logic [9:0] Q;
    logic       busy, valid, ov, dvz;

    int checks = 0;
    int errors = 0;

    div_top dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .busy  (busy),
        .valid (valid),
        .ov    (ov),
        .dvz   (dvz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] q;
        logic       ov;
        logic       dvz;
        int         lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a request; returns just after the accepting edge with start low.
    task automatic launch(input logic [9:0] a, input logic [9:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int lat0, output int lat);
        lat = lat0;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: valid never rose within 40 clocks");
        end
    endtask

    initial begin
        int lat;
        logic [9:0] q_hold;

        // Q4.6: value = raw/64; expected raw quotient = floor(a*64/b)
        vecs[0]  = '{10'b1101010000, 10'b0000011000, 10'd0,   1'b1, 1'b0, 18}; // 2261 ov
        vecs[1]  = '{10'b0000100000, 10'b0000010000, 10'd128, 1'b0, 1'b0, 18};
        vecs[2]  = '{10'b1101010000, 10'd0,          10'd0,   1'b0, 1'b1, 2};
        vecs[3]  = '{10'b0001000000, 10'b0011000000, 10'd21,  1'b0, 1'b0, 18};
        vecs[4]  = '{10'd1023,       10'd1023,       10'd64,  1'b0, 1'b0, 18};
        vecs[5]  = '{10'd1023,       10'd1,          10'd0,   1'b1, 1'b0, 18};
        vecs[6]  = '{10'd0,          10'd5,          10'd0,   1'b0, 1'b0, 18};
        vecs[7]  = '{10'd1023,       10'd64,         10'd1023,1'b0, 1'b0, 18}; // largest fit
        vecs[8]  = '{10'd1023,       10'd63,         10'd0,   1'b1, 1'b0, 18}; // 1039 ov
        vecs[9]  = '{10'd1,          10'd1023,       10'd0,   1'b0, 1'b0, 18};
        vecs[10] = '{10'd0,          10'd0,          10'd0,   1'b0, 1'b1, 2};
        vecs[11] = '{10'd640,        10'd160,        10'd256, 1'b0, 1'b0, 18};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_Q",     Q,     0);
        chk("reset_busy",  busy,  0);
        chk("reset_valid", valid, 0);
        chk("reset_ov",    ov,    0);
        chk("reset_dvz",   dvz,   0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i),   busy,  1);
            chk($sformatf("v%0d_vclr", i),   valid, 0);
            wait_valid(0, lat);
            chk($sformatf("v%0d_lat", i),    lat,   vecs[i].lat);
            chk($sformatf("v%0d_Q", i),      Q,     vecs[i].q);
            chk($sformatf("v%0d_ov", i),     ov,    vecs[i].ov);
            chk($sformatf("v%0d_dvz", i),    dvz,   vecs[i].dvz);
            chk($sformatf("v%0d_busy0", i),  busy,  0);
        end

        // Start pulsed mid-run must be ignored
        launch(10'b0000100000, 10'b0000010000);
        lat = 0;
        repeat (5) begin
            @(posedge clk);
            #1 lat++;
        end
        @(negedge clk);
        A     = 10'd1023;
        B     = 10'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat++;
        wait_valid(lat, lat);
        chk("busy_start_lat", lat, 18);
        chk("busy_start_Q",   Q,   128);
        chk("busy_start_ov",  ov,  0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_valid", valid, 1);
        chk("hold_busy",  busy,  0);
        chk("hold_Q",     Q,     128);

        // Asynchronous reset partway through the iterations
        launch(10'd640, 10'd160);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy",  busy,  0);
        chk("abort_valid", valid, 0);
        chk("abort_Q",     Q,     0);
        chk("abort_ov",    ov,    0);
        chk("abort_dvz",   dvz,   0);
        @(negedge clk) rst = 1'b1;
        launch(10'b0001000000, 10'b0011000000);
        wait_valid(0, lat);
        chk("after_rst_lat", lat, 18);
        chk("after_rst_Q",   Q,   21);
        chk("after_rst_ov",  ov,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
